// File: rtl/sequence_input_compare_if.sv
// Sample/output bundle for sequence_input_compare.
// master drives inp and observes the sorted stream; slave is the sorter.
interface sequence_input_compare_if #(
  parameter int DW = 3
);
  logic [DW-1:0] inp;
  logic [DW-1:0] outp;
  logic          out_valid;
  logic          out_first;

  modport master (
    output inp,
    input  outp,
    input  out_valid,
    input  out_first
  );

  modport slave (
    input  inp,
    output outp,
    output out_valid,
    output out_first
  );
endinterface

// File: rtl/sequence_input_compare.sv
// Sorts each 4-sample frame and replays it, one element per cycle, next frame.
// Ports: clk, rst_n (async low), bus.slave {inp, outp, out_valid, out_first}.
// Build macro: SEQ_CMP_DESCEND_EN selects descending order (default ascending).
module sequence_input_compare #(
  parameter int DW = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sequence_input_compare_if.slave   bus
);

  logic [1:0]    cnt;
  logic [DW-1:0] slot   [0:2];
  logic [DW-1:0] outbuf [0:3];
  logic          vld;

  // True when a must precede b in the sorted frame.
  function automatic logic first_of(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
`ifdef SEQ_CMP_DESCEND_EN
    return a >= b;
`else
    return a <= b;
`endif
  endfunction

  // Compare-exchange: upper half is the element that comes first.
  function automatic logic [2*DW-1:0] cx(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    return first_of(a, b) ? {a, b} : {b, a};
  endfunction

  logic [DW-1:0] a0, a1, a2, a3;
  logic [DW-1:0] b0, b1, b2, b3;
  logic [DW-1:0] c1, c2;

  // Slot 3 is never stored: the live sample joins the sort directly.
  assign {a0, a1} = cx(slot[0], slot[1]);
  assign {a2, a3} = cx(slot[2], bus.inp);
  assign {b0, b2} = cx(a0, a2);
  assign {b1, b3} = cx(a1, a3);
  assign {c1, c2} = cx(b1, b2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      vld       <= 1'b0;
      slot[0]   <= '0;
      slot[1]   <= '0;
      slot[2]   <= '0;
      outbuf[0] <= '0;
      outbuf[1] <= '0;
      outbuf[2] <= '0;
      outbuf[3] <= '0;
    end else begin
      cnt <= cnt + 2'd1;
      if (cnt != 2'd3) begin
        slot[cnt] <= bus.inp;
      end else begin
        outbuf[0] <= b0;
        outbuf[1] <= c1;
        outbuf[2] <= c2;
        outbuf[3] <= b3;
        vld       <= 1'b1;
      end
    end
  end

  assign bus.outp      = outbuf[cnt];
  assign bus.out_valid = vld;
  assign bus.out_first = vld & (cnt == 2'd0);

endmodule

// File: tb/tb_sequence_input_compare.sv
// Directed and random frames against a queue-sorting reference model.
// Order follows SEQ_CMP_DESCEND_EN, matching the design build.
module tb_sequence_input_compare;

  localparam int DW = 3;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sequence_input_compare_if #(.DW(DW)) bus ();

  sequence_input_compare #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int mcnt;
  int mvalid;
  int mframe [4];
  int mout   [4];
  int seen   [$];

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mcnt   = 0;
    mvalid = 0;
    for (int i = 0; i < 4; i++) mout[i] = 0;
    seen.delete();
  endtask

  task automatic model_load();
    int q [$];
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(mframe[i]);
`ifdef SEQ_CMP_DESCEND_EN
    q.rsort();
`else
    q.sort();
`endif
    for (int i = 0; i < 4; i++) mout[i] = q[i];
    mvalid = 1;
  endtask

  // One cycle: drive v, check this cycle's outputs, then clock it in.
  task automatic cycle(input int v);
    bus.inp = v[DW-1:0];
    #1;
    chk("outp", {29'd0, bus.outp}, mvalid ? mout[mcnt] : 0);
    chk("out_valid", {31'd0, bus.out_valid}, mvalid);
    chk("out_first", {31'd0, bus.out_first},
        (mvalid != 0 && mcnt == 0) ? 1 : 0);
    seen.push_back(int'(bus.outp));
    @(posedge clk);
    mframe[mcnt] = v;
    if (mcnt == 3) model_load();
    mcnt = (mcnt + 1) % 4;
    #1;
  endtask

  // Explicit expected values written from the frame rules by hand.
  task automatic chk_seen(
    input string tag,
    input int    base,
    input int    e0,
    input int    e1,
    input int    e2,
    input int    e3
  );
    int e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < 4; i++) begin
      if (seen.size() > base + i)
        chk(tag, seen[base+i], e[i]);
      else
        chk({tag, "_missing"}, 32'hffff_ffff, e[i]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_outp", {29'd0, bus.outp}, 0);
    chk("rst_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_first", {31'd0, bus.out_first}, 0);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    bus.inp = '0;
    model_reset();

    // Reset, release before first edge.
    do_reset();

    // 5,2,7,1 / 3,3,0,3 / 7,6,5,4 / 0,7,7,0 back to back, then flush.
    cycle(5); cycle(2); cycle(7); cycle(1);
    cycle(3); cycle(3); cycle(0); cycle(3);
    cycle(7); cycle(6); cycle(5); cycle(4);
    cycle(0); cycle(7); cycle(7); cycle(0);
    cycle(0); cycle(0); cycle(0); cycle(0);
    for (int i = 0; i < 4; i++) chk("pre_valid", seen[i], 0);
`ifdef SEQ_CMP_DESCEND_EN
    chk_seen("frame_5271", 4, 7, 5, 2, 1);
    chk_seen("frame_3303", 8, 3, 3, 3, 0);
    chk_seen("frame_7654", 12, 7, 6, 5, 4);
    chk_seen("frame_0770", 16, 7, 7, 0, 0);
`else
    chk_seen("frame_5271", 4, 1, 2, 5, 7);
    chk_seen("frame_3303", 8, 0, 3, 3, 3);
    chk_seen("frame_7654", 12, 4, 5, 6, 7);
    chk_seen("frame_0770", 16, 0, 0, 7, 7);
`endif

    // Mid-frame reset discards the partial frame 6,1.
    cycle(6); cycle(1);
    do_reset();
    cycle(2); cycle(4); cycle(1); cycle(3);
    for (int i = 0; i < 4; i++) cycle(int'($urandom_range(7)));
`ifdef SEQ_CMP_DESCEND_EN
    chk_seen("after_reset", 4, 4, 3, 2, 1);
`else
    chk_seen("after_reset", 4, 1, 2, 3, 4);
`endif

    // Constant input 5.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(5);
    for (int i = 4; i < 16; i++) chk("const5", seen[i], 5);

    // Random frames, including random mid-frame resets.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      cycle(int'($urandom_range(7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sequence_input_compare.md
SEQUENCE_INPUT_COMPARE -- requirements
Module: sequence_input_compare

Interface
REQ-001 The block SHALL have parameter DW, default 3, giving the sample and output width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all registers update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port inp, input, DW bits, one unsigned sample accepted every clock cycle.
REQ-005 The block SHALL have port outp, output, DW bits, one element of the sorted previous frame per cycle.
REQ-006 The block SHALL have port out_valid, output, 1 bit, high while outp carries a sorted element.
REQ-007 The block SHALL have port out_first, output, 1 bit, high in the cycle outp carries element 0 of a frame.

Function
REQ-008 The block SHALL keep a 2-bit free-running frame counter, cnt, that increments every cycle and wraps 3->0; a frame is 4 consecutive cycles, cnt=0..3.
REQ-009 On each rising edge the block SHALL capture inp into capture slot cnt; there is no input handshake, and every cycle's sample is consumed.
REQ-010 On the edge where cnt==3, the block SHALL sort slots 0..2 plus the current inp (as slot 3) through a 4-input compare-exchange network and load the result into a 4-entry output buffer in the same edge.
REQ-011 Compares SHALL be unsigned over the full DW bits; duplicate values SHALL all be retained, and no value is dropped or merged.
REQ-012 outp SHALL equal outbuf[cnt], so the 4 sorted elements of frame N appear in the 4 cycles of frame N+1, in order (element 0 first).
REQ-013 Latency: the first sample of a frame is captured at edge e0; element 0 of that frame is on outp after edge e3, i.e. 4 cycles later, with back-to-back frames and no bubbles.
REQ-014 out_valid SHALL be 0 until the first load edge after reset, then stay 1 continuously.
REQ-015 out_first SHALL equal out_valid AND (cnt==0).
REQ-016 Loading the output buffer at cnt==3 SHALL NOT disturb the element shown at that cycle; the new content is visible only from the next cycle.

Reset
REQ-017 While rst_n=0, the block SHALL set cnt=0, clear all capture slots and output buffer entries to 0, and drive outp=0, out_valid=0 and out_first=0, independent of clk.
REQ-018 A reset asserted mid-frame SHALL discard the partial frame; after release, the first sample is captured into slot 0.

Configuration
REQ-019 The macro SEQ_CMP_DESCEND_EN SHALL control sort order.
REQ-020 When SEQ_CMP_DESCEND_EN is defined, element 0 SHALL be the largest value (descending).
REQ-021 When SEQ_CMP_DESCEND_EN is undefined, element 0 SHALL be the smallest value (ascending); this is the default.
REQ-022 SEQ_CMP_DESCEND_EN SHALL change only compare direction; timing and ports SHALL be identical in both builds.

Verification (DW=3, reset released before the first edge)
REQ-023 The bench SHALL drive inp 5,2,7,1 and require outp 1,2,5,7 in cycles 4..7, with out_first=1 only in cycle 4 and out_valid=0 in cycles 0..3.
REQ-024 The bench SHALL drive inp 5,2,7,1 with SEQ_CMP_DESCEND_EN defined and require outp 7,5,2,1.
REQ-025 The bench SHALL drive inp 3,3,0,3 and require outp 0,3,3,3.
REQ-026 The bench SHALL drive back-to-back frames 7,6,5,4 then 0,7,7,0 and require outp 4,5,6,7 then 0,0,7,7 with no gap cycle.
REQ-027 The bench SHALL feed 6,1 and then pulse rst_n low between edges; it SHALL require outp=0 and out_valid=0 immediately, then, after feeding 2,4,1,3, require outp 1,2,3,4.
REQ-028 The bench SHALL hold inp=5 constant and require outp=5 every cycle from cycle 4 onward, with out_valid held at 1.
